// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner.
package keypad_pkg;

    localparam int unsigned DefaultRows = 4;
    localparam int unsigned DefaultCols = 4;

    // Debounce FSM states
    typedef enum logic [1:0] {
        StIdle,
        StCandidate,
        StHeld,
        StReleasing
    } scan_state_e;

    // Classification of one complete scan frame
    typedef enum logic [1:0] {
        FrNone,
        FrSingle,
        FrMulti
    } frame_res_e;

    // Ceiling log2 for elaboration-time widths (values >= 2 expected)
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Column strobe generator: holds each active-low column for SCAN_DIV clocks,
// flags the sampling cycle and the last sample of a frame.
module keypad_col_driver
    import keypad_pkg::*;
#(
    parameter int unsigned COLS     = DefaultCols,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic [COLS-1:0]            col_o,
    output logic [clog2(COLS)-1:0]     col_idx_o,
    output logic                       sample_en_o,
    output logic                       frame_end_o
);

    localparam int unsigned DwellW = clog2(SCAN_DIV);
    localparam int unsigned ColW   = clog2(COLS);

    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [ColW-1:0]   col_idx_q, col_idx_d;

    // Next-state for dwell and column counters plus decoded strobes
    always_comb begin
        sample_en_o = (dwell_q == DwellW'(SCAN_DIV - 1));
        frame_end_o = sample_en_o && (col_idx_q == ColW'(COLS - 1));
        dwell_d     = sample_en_o ? '0 : dwell_q + DwellW'(1);
        col_idx_d   = col_idx_q;
        if (sample_en_o) begin
            col_idx_d = (col_idx_q == ColW'(COLS - 1)) ? '0 : col_idx_q + ColW'(1);
        end
        for (int c = 0; c < int'(COLS); c++) begin
            col_o[c] = (col_idx_q != ColW'(c));
        end
    end

    assign col_idx_o = col_idx_q;

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dwell_q   <= '0;
            col_idx_q <= '0;
        end else begin
            dwell_q   <= dwell_d;
            col_idx_q <= col_idx_d;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner with frame-based debounce, press/release strobes and
// multi-key detection.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS           = DefaultRows,
    parameter int unsigned COLS           = DefaultCols,
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned CODE_W         = clog2(ROWS * COLS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_press,
    output logic              key_release,
    output logic              multi_key
);

    localparam int unsigned RowW    = clog2(ROWS);
    localparam int unsigned ColW    = clog2(COLS);
    localparam logic [3:0]  DebLast = 4'(DEBOUNCE_SCANS);

    logic [ColW-1:0] col_idx;
    logic            sample_en;
    logic            frame_end;

    keypad_col_driver #(
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_col_driver (
        .clk_i       (clock),
        .rst_i       (reset),
        .col_o       (col),
        .col_idx_o   (col_idx),
        .sample_en_o (sample_en),
        .frame_end_o (frame_end)
    );

    logic [ROWS-1:0] row_meta_q, row_sync_q;

    // Two-flop synchroniser; all ones means no key pressed
    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    logic [1:0]      samp_cnt;
    logic [RowW-1:0] samp_row;

    // Pressed-bit count (saturating at 2) and lowest pressed row of this column
    always_comb begin
        samp_cnt = 2'd0;
        samp_row = '0;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if (!row_sync_q[r]) begin
                samp_row = RowW'(r);
            end
        end
        for (int r = 0; r < int'(ROWS); r++) begin
            if (!row_sync_q[r] && samp_cnt != 2'd2) begin
                samp_cnt = samp_cnt + 2'd1;
            end
        end
    end

    logic [1:0]        acc_cnt_q, tot_cnt;
    logic [CODE_W-1:0] acc_idx_q, tot_idx;
    logic [2:0]        cnt_sum;
    frame_res_e        frame_res;

    // Frame totals including the sample taken this cycle, so the last column
    // is part of the result the FSM sees at frame end
    always_comb begin
        tot_cnt = acc_cnt_q;
        tot_idx = acc_idx_q;
        cnt_sum = {1'b0, acc_cnt_q} + {1'b0, samp_cnt};
        if (sample_en) begin
            tot_cnt = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
            if (acc_cnt_q == 2'd0 && samp_cnt != 2'd0) begin
                tot_idx = CODE_W'(col_idx) * CODE_W'(ROWS) + CODE_W'(samp_row);
            end
        end
        if (tot_cnt == 2'd0) begin
            frame_res = FrNone;
        end else if (tot_cnt == 2'd1) begin
            frame_res = FrSingle;
        end else begin
            frame_res = FrMulti;
        end
    end

    // Per-frame accumulator, cleared as each frame is handed to the FSM
    always_ff @(posedge clock) begin
        if (reset || frame_end) begin
            acc_cnt_q <= '0;
            acc_idx_q <= '0;
        end else if (sample_en) begin
            acc_cnt_q <= tot_cnt;
            acc_idx_q <= tot_idx;
        end
    end

    scan_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d, cnt_inc;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              press_arm_q, press_arm_d;
    logic              key_press_q;
    logic              key_release_q, key_release_d;
    logic              multi_key_q, multi_key_d;

    // Debounce next-state: one decision per completed frame
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        key_code_d    = key_code_q;
        key_valid_d   = key_valid_q;
        press_arm_d   = 1'b0;
        key_release_d = 1'b0;
        multi_key_d   = multi_key_q;
        cnt_inc       = cnt_q + 4'd1;
        if (frame_end) begin
            multi_key_d = (frame_res == FrMulti);
            unique case (state_q)
                StIdle: begin
                    if (frame_res == FrSingle) begin
                        cand_d = tot_idx;
                        cnt_d  = 4'd1;
                        if (DebLast == 4'd1) begin
                            key_code_d  = tot_idx;
                            key_valid_d = 1'b1;
                            press_arm_d = 1'b1;
                            state_d     = StHeld;
                        end else begin
                            state_d = StCandidate;
                        end
                    end
                end
                StCandidate: begin
                    if (frame_res == FrSingle && tot_idx == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebLast) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            press_arm_d = 1'b1;
                            state_d     = StHeld;
                        end
                    end else if (frame_res == FrSingle) begin
                        cand_d = tot_idx;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    // A different single key counts as the held key going away
                    if (frame_res == FrNone ||
                        (frame_res == FrSingle && tot_idx != key_code_q)) begin
                        cnt_d = 4'd1;
                        if (DebLast == 4'd1) begin
                            key_valid_d   = 1'b0;
                            key_release_d = 1'b1;
                            state_d       = StIdle;
                        end else begin
                            state_d = StReleasing;
                        end
                    end
                end
                StReleasing: begin
                    if (frame_res == FrNone) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebLast) begin
                            key_valid_d   = 1'b0;
                            key_release_d = 1'b1;
                            state_d       = StIdle;
                        end
                    end else begin
                        state_d = StHeld;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM and output registers; key_press trails acceptance by one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            cand_q        <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            press_arm_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            multi_key_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            press_arm_q   <= press_arm_d;
            key_press_q   <= press_arm_q;
            key_release_q <= key_release_d;
            multi_key_q   <= multi_key_d;
        end
    end

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign multi_key   = multi_key_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a keypad matrix model drives the rows from
// the column outputs, and a frame-level reference predicts every output.
module tb_keypad_scan_debounce;

    localparam int unsigned ROWS     = 4;
    localparam int unsigned COLS     = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned NK       = ROWS * COLS;
    localparam int          F        = int'(COLS * SCAN_DIV);

    logic              clock = 1'b0;
    logic              reset;
    logic [ROWS-1:0]   row;
    logic [COLS-1:0]   col;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_press;
    logic              key_release;
    logic              multi_key;

    logic [NK-1:0]     keys;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    // Reference state: held flag, held code, candidate and run lengths
    bit m_held;
    int m_code;
    int m_cand;
    int m_run;
    int m_absent;
    bit e_valid, e_multi, e_release, e_press, press_pending;
    int e_code;

    always #5 clock = ~clock;

    keypad_scan_debounce #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_press   (key_press),
        .key_release (key_release),
        .multi_key   (multi_key)
    );

    // Key k = c*ROWS + r pulls row r low while column c is driven low
    always_comb begin
        row = '1;
        for (int c = 0; c < int'(COLS); c++) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                if (!col[c] && keys[c * int'(ROWS) + r]) row[r] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_code = 0; m_cand = 0; m_run = 0; m_absent = 0;
        e_valid = 0; e_multi = 0; e_release = 0; e_press = 0; press_pending = 0;
        e_code = 0;
        t = 0;
    endtask

    // One completed frame with key set k; sets expectations for the next cycle
    task automatic model_frame(input logic [NK-1:0] k);
        int n;
        int idx;
        bit single;
        bit absent;
        n = $countones(k);
        idx = 0;
        for (int i = int'(NK) - 1; i >= 0; i--) if (k[i]) idx = i;
        single = (n == 1);
        e_multi = (n >= 2);
        e_release = 0;
        if (!m_held) begin
            if (single) begin
                if (m_run > 0 && idx == m_cand) m_run++;
                else begin
                    m_cand = idx;
                    m_run = 1;
                end
            end else begin
                m_run = 0;
            end
            if (m_run >= int'(DEB)) begin
                m_held = 1;
                m_code = m_cand;
                m_run = 0;
                press_pending = 1;
            end
        end else begin
            absent = (n == 0) || (single && idx != m_code && m_absent == 0);
            if (absent) m_absent++;
            else m_absent = 0;
            if (m_absent >= int'(DEB)) begin
                m_held = 0;
                m_absent = 0;
                e_release = 1;
            end
        end
        e_valid = m_held;
        e_code = m_code;
    endtask

    // Check outputs of cycle t, then advance to cycle t+1
    task automatic step();
        logic [COLS-1:0] ec;
        ec = '1;
        ec[(t / int'(SCAN_DIV)) % int'(COLS)] = 1'b0;
        check_eq("col", 32'(col), 32'(ec));
        check_eq("key_code", 32'(key_code), 32'(e_code));
        check_eq("key_valid", 32'(key_valid), 32'(e_valid));
        check_eq("key_press", 32'(key_press), 32'(e_press));
        check_eq("key_release", 32'(key_release), 32'(e_release));
        check_eq("multi_key", 32'(multi_key), 32'(e_multi));
        if (t % F == F - 1) begin
            model_frame(keys);
            e_press = 0;
        end else begin
            e_release = 0;
            e_press = press_pending;
            press_pending = 0;
        end
        @(posedge clock);
        #1;
        t++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_frames(input logic [NK-1:0] k, input int n);
        keys = k;
        repeat (n * F) step();
    endtask

    task automatic reset_after(input logic [NK-1:0] k, input int n);
        keys = k;
        repeat (n) step();
        do_reset();
    endtask

    function automatic logic [NK-1:0] rand_keys();
        logic [NK-1:0] k;
        int sel;
        k = '0;
        sel = int'($urandom_range(0, 9));
        if (sel >= 4) k[$urandom_range(0, NK - 1)] = 1'b1;
        if (sel >= 8) k[$urandom_range(0, NK - 1)] = 1'b1;
        return k;
    endfunction

    localparam logic [NK-1:0] K0  = NK'(1);
    localparam logic [NK-1:0] K5  = NK'(1) << 5;
    localparam logic [NK-1:0] K6  = NK'(1) << 6;
    localparam logic [NK-1:0] K11 = NK'(1) << 11;

    initial begin
        logic [NK-1:0] k;
        reset = 1'b1;
        keys = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        run_frames('0, 10);                 // idle scan
        run_frames(K6, 5);                  // col 1 / row 2 held
        run_frames('0, 4);                  // release
        run_frames(K6, 2);                  // bounce
        run_frames('0, 1);
        run_frames(K6, 3);
        run_frames('0, 4);
        run_frames(K0 | K11, 3);            // ghosting frames
        run_frames(K0, 4);
        run_frames(K0 | K11, 3);            // multi while key 0 held
        run_frames('0, 4);
        run_frames(K5, 2);
        reset_after(K5, 7);                 // reset mid-candidate
        run_frames(K5, 4);
        reset_after(K5, 9);                 // reset mid-held
        run_frames(K5, 4);
        run_frames('0, 4);

        k = '0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) k = rand_keys();
            if ($urandom_range(0, 29) == 0) reset_after(k, int'($urandom_range(1, F - 1)));
            else run_frames(k, 1);
        end
        run_frames('0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
